// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Covers funct3 encodings, the FSM state type and the internal fault causes.
package lsu_pkg;

    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;
    localparam logic [2:0] SB  = 3'd0;
    localparam logic [2:0] SH  = 3'd1;
    localparam logic [2:0] SW  = 3'd2;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } lsu_state_t;

    typedef enum logic [2:0] {
        FAULT_NONE,
        FAULT_FUNCT3,
        FAULT_MISALIGN,
        FAULT_RANGE,
        FAULT_READONLY
    } fault_cause_t;

endpackage

// File: rtl/load_align.sv
// Sub-word load extraction: picks the byte/half lane from a memory word
// and sign- or zero-extends it according to the load funct3.
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        byte_val = word[{lane, 3'b000} +: 8];
        half_val = lane[1] ? word[31:16] : word[15:0];
        data     = 32'h0;
        case (funct3)
            LB:      data = {{24{byte_val[7]}}, byte_val};
            LH:      data = {{16{half_val[15]}}, half_val};
            LW:      data = word;
            LBU:     data = {24'h0, byte_val};
            LHU:     data = {16'h0, half_val};
            default: data = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: accepts one load/store from EX, does sub-word stores as
// read-modify-write of a whole word, and hands extended load data to WB.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int RO_WORDS    = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_rd,
    output logic        resp_is_load,
    output logic        resp_fault,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write_enable,
    output logic [3:0]  mem_write_mask,
    input  logic [31:0] mem_read_data
);

    localparam logic [29:0] DEPTH_IDX = 30'(DEPTH_WORDS);
    localparam logic [29:0] RO_IDX    = 30'(RO_WORDS);

    lsu_state_t   state_q, state_d;
    fault_cause_t cause;

    logic        is_load_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [4:0]  rd_q;
    logic [31:0] rdata_q;
    logic        fault_q;

    logic        kill;
    logic        fire;
    logic        misaligned;
    logic        illegal;
    logic        write_en;
    logic [29:0] word_idx;
    logic [31:0] merged;
    logic [31:0] load_data;

    // Reset mid-operation is treated exactly like a flush.
    assign kill      = flush | rst;
    assign req_ready = ~kill & ((state_q == IDLE) | ((state_q == RESP) & resp_ready));
    assign fire      = req_valid & req_ready;
    assign word_idx  = addr_q[31:2];

    always_comb begin
        misaligned = 1'b0;
        illegal    = 1'b0;
        case (funct3_q)
            LB: ;
            LH: misaligned = addr_q[0];
            LW: misaligned = |addr_q[1:0];
            LBU: illegal = ~is_load_q;
            LHU: begin
                illegal    = ~is_load_q;
                misaligned = addr_q[0];
            end
            default: illegal = 1'b1;
        endcase
        cause = FAULT_NONE;
        if (illegal)                                  cause = FAULT_FUNCT3;
        else if (misaligned)                          cause = FAULT_MISALIGN;
        else if (word_idx >= DEPTH_IDX)               cause = FAULT_RANGE;
        else if (~is_load_q && (word_idx < RO_IDX))   cause = FAULT_READONLY;
    end

    // The memory only writes whole words, so sub-word stores merge into the read word.
    always_comb begin
        merged = mem_read_data;
        case (funct3_q)
            SB:      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            SH:      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    load_align u_load_align (
        .word   (mem_read_data),
        .lane   (addr_q[1:0]),
        .funct3 (funct3_q),
        .data   (load_data)
    );

    assign write_en         = (state_q == ACCESS) & ~is_load_q & (cause == FAULT_NONE) & ~kill;
    assign mem_address      = {2'b00, addr_q[31:2]};
    assign mem_write_enable = write_en;
    assign mem_write_data   = write_en ? merged : 32'h0;
    assign mem_write_mask   = write_en ? 4'hF : 4'h0;

    assign resp_valid   = (state_q == RESP) & ~kill;
    assign resp_rdata   = rdata_q;
    assign resp_rd      = rd_q;
    assign resp_is_load = is_load_q;
    assign resp_fault   = fault_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fire) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    if (resp_ready) state_d = fire ? ACCESS : IDLE;
            default: state_d = IDLE;
        endcase
        if (kill) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            is_load_q <= 1'b0;
            funct3_q  <= 3'd0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            rd_q      <= 5'd0;
            rdata_q   <= 32'h0;
            fault_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (fire) begin
                is_load_q <= ~req_is_store;
                funct3_q  <= req_funct3;
                addr_q    <= req_addr;
                wdata_q   <= req_wdata;
                rd_q      <= req_rd;
            end
            if ((state_q == ACCESS) && !flush) begin
                fault_q <= (cause != FAULT_NONE);
                rdata_q <= (is_load_q && (cause == FAULT_NONE)) ? load_data : 32'h0;
            end
        end
    end

    a_write_only_clean_access: assert property (@(posedge clk) disable iff (rst)
        mem_write_enable |-> ((state_q == ACCESS) && (cause == FAULT_NONE)));

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a vector table of single operations
// plus hand-written stall, flush and reset sequences against a word memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_is_load;
    logic        resp_fault;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;
    logic [3:0]  mem_write_mask;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:1023];
    logic        init_mem;
    int          write_count = 0;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        logic        is_store;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] exp_rdata;
        logic        exp_fault;
        logic        exp_we;
        logic [31:0] exp_mem;
    } vec_t;

    vec_t vecs [24];

    load_store_unit #(.DEPTH_WORDS(1024), .RO_WORDS(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_is_store     (req_is_store),
        .req_funct3       (req_funct3),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .req_rd           (req_rd),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_rdata       (resp_rdata),
        .resp_rd          (resp_rd),
        .resp_is_load     (resp_is_load),
        .resp_fault       (resp_fault),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_write_mask   (mem_write_mask),
        .mem_read_data    (mem_read_data)
    );

    always #5 clk = ~clk;

    // Word memory: combinational read, masked whole-word write, plus a preload.
    assign mem_read_data = (mem_address < 32'd1024) ? mem[mem_address[9:0]] : 32'h0;

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'(i + 5);
            mem[40] <= 32'h8899AABB;
            mem[50] <= 32'hCAFEF00D;
        end else if (mem_write_enable) begin
            mem[mem_address[9:0]] <= mem_write_data & {{8{mem_write_mask[3]}}, {8{mem_write_mask[2]}},
                                                       {8{mem_write_mask[1]}}, {8{mem_write_mask[0]}}};
            write_count <= write_count + 1;
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    task automatic drive_req(input logic is_store, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [4:0] rd);
        req_valid    = 1'b1;
        req_is_store = is_store;
        req_funct3   = f3;
        req_addr     = addr;
        req_wdata    = wdata;
        req_rd       = rd;
    endtask

    task automatic apply_stimulus(input vec_t v, input string tag);
        int wc0;
        int n;
        @(negedge clk);
        drive_req(v.is_store, v.funct3, v.addr, v.wdata, v.rd);
        resp_ready = 1'b1;
        wc0 = write_count;
        #1 check_output({tag, " req_ready"}, 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        #1 check_output({tag, " write_enable"}, 32'(mem_write_enable), 32'(v.exp_we));
        if (v.exp_we) begin
            check_output({tag, " mem_address"}, mem_address, {2'b00, v.addr[31:2]});
            check_output({tag, " mem_write_data"}, mem_write_data, v.exp_mem);
            check_output({tag, " mem_write_mask"}, 32'(mem_write_mask), 32'hF);
        end
        n = 0;
        while (!resp_valid && n < 6) begin
            @(negedge clk);
            #1 n++;
        end
        check_output({tag, " latency"}, 32'(n), 32'd1);
        check_output({tag, " resp_rdata"}, resp_rdata, v.exp_rdata);
        check_output({tag, " resp_fault"}, 32'(resp_fault), 32'(v.exp_fault));
        check_output({tag, " resp_rd"}, 32'(resp_rd), 32'(v.rd));
        check_output({tag, " resp_is_load"}, 32'(resp_is_load), 32'(!v.is_store));
        check_output({tag, " write_count"}, 32'(write_count - wc0), 32'(v.exp_we));
    endtask

    initial begin
        vecs[0]  = '{1'b0, 3'd0, 32'hA1,   32'h0,        5'd1,  32'hFFFFFFAA, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 3'd4, 32'hA1,   32'h0,        5'd2,  32'h000000AA, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 3'd5, 32'hA2,   32'h0,        5'd3,  32'h00008899, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 3'd1, 32'hA2,   32'h0,        5'd4,  32'hFFFF8899, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 3'd0, 32'hA2,   32'h12345677, 5'd5,  32'h0,        1'b0, 1'b1, 32'h8877AABB};
        vecs[5]  = '{1'b0, 3'd2, 32'hA0,   32'h0,        5'd6,  32'h8877AABB, 1'b0, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 3'd2, 32'h0C,   32'h0,        5'd7,  32'h00000008, 1'b0, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 3'd2, 32'h10,   32'hDEADBEEF, 5'd8,  32'h0,        1'b1, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 3'd1, 32'hA1,   32'h0,        5'd9,  32'h0,        1'b1, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 3'd3, 32'hA0,   32'h0,        5'd10, 32'h0,        1'b1, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 3'd2, 32'h1000, 32'h0,        5'd11, 32'h0,        1'b1, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 3'd1, 32'hA0,   32'hDEAD1234, 5'd12, 32'h0,        1'b0, 1'b1, 32'h88771234};
        vecs[12] = '{1'b0, 3'd2, 32'hA0,   32'h0,        5'd13, 32'h88771234, 1'b0, 1'b0, 32'h0};
        vecs[13] = '{1'b1, 3'd2, 32'h100,  32'h11223344, 5'd14, 32'h0,        1'b0, 1'b1, 32'h11223344};
        vecs[14] = '{1'b0, 3'd0, 32'h103,  32'h0,        5'd15, 32'h00000011, 1'b0, 1'b0, 32'h0};
        vecs[15] = '{1'b1, 3'd3, 32'h100,  32'h55555555, 5'd16, 32'h0,        1'b1, 1'b0, 32'h0};
        vecs[16] = '{1'b1, 3'd2, 32'h102,  32'h55555555, 5'd17, 32'h0,        1'b1, 1'b0, 32'h0};
        vecs[17] = '{1'b0, 3'd2, 32'hFFC,  32'h0,        5'd18, 32'h00000404, 1'b0, 1'b0, 32'h0};
        vecs[18] = '{1'b1, 3'd2, 32'h80,   32'hA5A5A5A5, 5'd19, 32'h0,        1'b0, 1'b1, 32'hA5A5A5A5};
        vecs[19] = '{1'b0, 3'd2, 32'h80,   32'h0,        5'd20, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0};
        vecs[20] = '{1'b1, 3'd0, 32'h7C,   32'h000000FF, 5'd21, 32'h0,        1'b1, 1'b0, 32'h0};
        vecs[21] = '{1'b0, 3'd6, 32'hA0,   32'h0,        5'd22, 32'h0,        1'b1, 1'b0, 32'h0};
        vecs[22] = '{1'b0, 3'd0, 32'h1003, 32'h0,        5'd23, 32'h0,        1'b1, 1'b0, 32'h0};
        vecs[23] = '{1'b0, 3'd1, 32'h102,  32'h0,        5'd24, 32'h00001122, 1'b0, 1'b0, 32'h0};

        rst = 1'b1;
        init_mem = 1'b1;
        flush = 1'b0;
        req_valid = 1'b0;
        req_is_store = 1'b0;
        req_funct3 = 3'd0;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        req_rd = 5'd0;
        resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        init_mem = 1'b0;
        rst = 1'b0;
        #1;
        check_output("reset req_ready", 32'(req_ready), 32'd1);
        check_output("reset resp_valid", 32'(resp_valid), 32'd0);
        check_output("reset resp_rdata", resp_rdata, 32'h0);
        check_output("reset resp_fault", 32'(resp_fault), 32'd0);
        check_output("reset resp_is_load", 32'(resp_is_load), 32'd0);
        check_output("reset write_enable", 32'(mem_write_enable), 32'd0);
        check_output("reset mem_address", mem_address, 32'h0);
        check_output("reset mem_write_mask", 32'(mem_write_mask), 32'h0);

        for (int i = 0; i < 24; i++) apply_stimulus(vecs[i], $sformatf("v%0d", i));

        // Stall in RESP for three cycles, then a back-to-back acceptance.
        @(negedge clk);
        drive_req(1'b0, 3'd2, 32'hA0, 32'h0, 5'd7);
        resp_ready = 1'b0;
        @(negedge clk);
        drive_req(1'b0, 3'd4, 32'hA1, 32'h0, 5'd9);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check_output($sformatf("stall%0d resp_valid", k), 32'(resp_valid), 32'd1);
            check_output($sformatf("stall%0d resp_rdata", k), resp_rdata, 32'h88771234);
            check_output($sformatf("stall%0d resp_rd", k), 32'(resp_rd), 32'd7);
            check_output($sformatf("stall%0d req_ready", k), 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        #1 check_output("b2b req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        #1 check_output("b2b access resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        #1;
        check_output("b2b resp_valid", 32'(resp_valid), 32'd1);
        check_output("b2b resp_rdata", resp_rdata, 32'h00000012);
        check_output("b2b resp_rd", 32'(resp_rd), 32'd9);

        // Flush while a store sits in ACCESS: no write, no response.
        @(negedge clk);
        drive_req(1'b1, 3'd2, 32'hC8, 32'h01020304, 5'd1);
        @(negedge clk);
        req_valid = 1'b0;
        flush = 1'b1;
        #1;
        check_output("flush write_enable", 32'(mem_write_enable), 32'd0);
        check_output("flush req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check_output("flush resp_valid", 32'(resp_valid), 32'd0);
        check_output("flush idle req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        #1 check_output("flush later resp_valid", 32'(resp_valid), 32'd0);
        apply_stimulus('{1'b0, 3'd2, 32'hC8, 32'h0, 5'd2, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0}, "flush_readback");

        // Reset while a response is waiting.
        @(negedge clk);
        drive_req(1'b0, 3'd2, 32'hA0, 32'h0, 5'd3);
        resp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #1 check_output("rst pre resp_valid", 32'(resp_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        resp_ready = 1'b1;
        #1;
        check_output("rst resp_valid", 32'(resp_valid), 32'd0);
        check_output("rst req_ready", 32'(req_ready), 32'd1);
        check_output("rst resp_rdata", resp_rdata, 32'h0);
        check_output("rst resp_rd", 32'(resp_rd), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage of the pipelined core. Sits directly upstream of the data memory and drives its word-indexed port.
- Accepts one load/store per handshake from EX and translates the byte address into the memory's word index.
- The data memory writes whole words with its mask ANDed into the data, so sub-word stores are done here as read-modify-write with the full mask.
- Performs sub-word load extraction and extension, and returns the result to WB over a valid/ready handshake.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in data memory; word index >= DEPTH_WORDS faults
RO_WORDS, 32, word indices [0, RO_WORDS) are a read-only constant region; stores there fault

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
flush  input  1  pipeline flush, synchronous
req_valid  input  1  EX presents an operation
req_ready  output  1  unit accepts the operation this cycle
req_is_store  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I load/store funct3
req_addr  input  32  byte address
req_wdata  input  32  store data (low bits used for SB/SH)
req_rd  input  5  load destination register
resp_valid  output  1  result available to WB
resp_ready  input  1  WB consumes result
resp_rdata  output  32  extended load data; 0 for stores and faults
resp_rd  output  5  captured req_rd
resp_is_load  output  1  captured ~req_is_store
resp_fault  output  1  misaligned, illegal funct3, out-of-range, or store to read-only region
mem_address  output  32  word index = {2'b0, addr[31:2]}
mem_write_data  output  32  full merged word
mem_write_enable  output  1  one-cycle write strobe
mem_write_mask  output  4  always 4'hF while mem_write_enable=1, else 4'h0
mem_read_data  input  32  combinational read of mem_address

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: state IDLE. All outputs 0 except req_ready=1. Captured request fields cleared.
- States:
  - IDLE: req_ready=1. On fire (req_valid & req_ready & ~flush), capture the request, go to ACCESS.
  - ACCESS: mem_address driven from the captured address. Evaluate fault.
    - Load, no fault: load_align(mem_read_data, addr[1:0], funct3) is registered into resp_rdata.
    - Store, no fault: merge the store data into mem_read_data at byte lane addr[1:0]. Drive mem_write_data=merged, mem_write_enable=1, mem_write_mask=4'hF for this single cycle.
    - Then go to RESP.
  - RESP: resp_valid=1 and held with stable outputs while resp_ready=0.
    - req_ready = resp_ready.
    - resp_ready & new fire: go to ACCESS (back-to-back).
    - resp_ready & no fire: go to IDLE.
- Latency: fire at cycle N gives resp_valid at N+2. Peak throughput is 1 op / 2 cycles.
- Faults (no memory write; resp_rdata=0, resp_fault=1):
  - Misalignment: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0.
  - Illegal funct3: load funct3 in {3,6,7}; store funct3 >= 3.
  - Out of range: addr[31:2] >= DEPTH_WORDS.
  - Store to the read-only region: addr[31:2] < RO_WORDS.
- Load extension:
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - Lane select is byte addr[1:0] or half addr[1].
- Flush:
  - Highest priority; clears the pending op and goes to IDLE next cycle.
  - In ACCESS it suppresses mem_write_enable that cycle.
  - In RESP it drops resp_valid.
  - Blocks acceptance that cycle (req_ready=0).
- Reset mid-operation: behaves like flush, and the write is suppressed in that cycle.
- mem_write_enable never asserts outside ACCESS.

Decomposition:
- Package lsu_pkg:
  - funct3 constants LB=0, LH=1, LW=2, LBU=4, LHU=5, SB=0, SH=1, SW=2.
  - State enum lsu_state_t {IDLE, ACCESS, RESP}.
  - Fault-cause enum (used only internally and in assertions).
- Sub-module load_align: combinational lane select and sign/zero extension. The store merge stays inline.

Test Plan:
- Preload word 40=0x8899AABB. LB addr 0xA1 -> resp_rdata=0xFFFFFFAA at N+2; LBU -> 0x000000AA; LHU 0xA2 -> 0x00008899.
- SB addr 0xA2, wdata 0x12345677 -> in ACCESS mem_address=40, mem_write_data=0x8877AABB, mask=4'hF, write_enable for exactly 1 cycle; a following LW 0xA0 -> 0x8877AABB.
- LW addr 0x0C -> 0x00000008 (constant region). SW addr 0x10 -> resp_fault=1, mem_write_enable never asserted.
- LH addr 0xA1 -> resp_fault=1, resp_rdata=0. Load funct3=3 -> fault. LW addr 0x1000 (word 1024) -> fault.
- resp_ready held 0 for 3 cycles in RESP -> resp_valid/resp_rdata/resp_rd stable, req_ready=0; then resp_ready=1 with req_valid=1 -> next op accepted the same cycle, its resp_valid 2 cycles later.
- SW to word 50 with flush asserted during ACCESS -> no write (word 50 unchanged), no resp_valid. rst during RESP -> next cycle resp_valid=0, req_ready=1.
